// File: rtl/mem_pkg.sv
// Shared encodings and decode helpers for the byte-serial memory-access stage.
package mem_pkg;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LW   = 4'd3,
        MEMOP_LBU  = 4'd4,
        MEMOP_LHU  = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [2:0] memop_nbytes(input logic [3:0] op);
        logic [2:0] n;
        n = 3'd0;
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: n = 3'd1;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: n = 3'd2;
            MEMOP_LW, MEMOP_SW:            n = 3'd4;
            default:                       n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic memop_is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Unknown codes decode to zero bytes and so behave exactly like NONE.
    function automatic logic memop_is_mem(input logic [3:0] op);
        return memop_nbytes(op) != 3'd0;
    endfunction

    function automatic logic memop_is_signed(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LH);
    endfunction

    function automatic logic memop_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic [2:0] n;
        n = memop_nbytes(op);
        return ((n == 3'd2) && addr_lo[0]) || ((n == 3'd4) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load write-back formatter: picks byte/half/word from the assembly buffer and extends it.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] lanes_i,
    input  logic [2:0]  nbytes_i,
    input  logic        signed_i,
    output logic [31:0] wdata_o
);

    always_comb begin
        wdata_o = lanes_i;
        case (nbytes_i)
            3'd1:    wdata_o = {{24{signed_i & lanes_i[7]}}, lanes_i[7:0]};
            3'd2:    wdata_o = {{16{signed_i & lanes_i[15]}}, lanes_i[15:0]};
            default: wdata_o = lanes_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores as byte transactions on a byte-wide port, stalling upstream meanwhile.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a one-cycle misalign pulse.
//
// state  | meaning
// IDLE   | pass ALU results through; a memory op latches and starts
// ACCESS | issue bytes and (for loads) collect returned bytes
// DONE   | one cycle of write-back, stall released
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [3:0]        ex_memop,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              stall_req,
    output logic [4:0]        o_wd,
    output logic              o_wreg,
    output logic [DATA_W-1:0] o_wdata
);

    state_e            state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic [4:0]        wd_q;
    logic [2:0]        nbytes_q;
    logic [2:0]        issue_cnt_q;
    logic [2:0]        recv_cnt_q;
    logic              pend_q;
    logic [31:0]       lanes_q;

    logic              ex_is_mem;
    logic              misalign_c;
    logic              req_c;
    logic              grant_c;
    logic [31:0]       ext_wdata;

    mem_load_ext u_load_ext (
        .lanes_i  (lanes_q),
        .nbytes_i (nbytes_q),
        .signed_i (memop_is_signed(op_q)),
        .wdata_o  (ext_wdata)
    );

    assign ex_is_mem = memop_is_mem(ex_memop);
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = ex_is_mem && memop_misaligned(ex_memop, ex_mem_addr[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    assign req_c   = (state_q == ST_ACCESS) && (issue_cnt_q != nbytes_q);
    assign grant_c = req_c && mem_gnt;

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_dout  = 8'h00;
        stall_req = 1'b0;
        o_wd      = 5'd0;
        o_wreg    = 1'b0;
        o_wdata   = '0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ex_is_mem && !misalign_c) begin
                    stall_req = 1'b1;
                    state_d   = ST_ACCESS;
                end else if (ex_is_mem) begin
`ifdef MEM_ALIGN_CHECK_EN
                    misalign  = 1'b1;
`endif
                end else begin
                    o_wd    = ex_wd;
                    o_wreg  = ex_wreg;
                    o_wdata = ex_wdata;
                end
            end
            ST_ACCESS: begin
                stall_req = 1'b1;
                mem_req   = req_c;
                mem_we    = memop_is_store(op_q);
                mem_a     = addr_q + ADDR_W'(issue_cnt_q);
                mem_dout  = store_q[{issue_cnt_q[1:0], 3'b000} +: 8];
                if (memop_is_store(op_q)) begin
                    if (grant_c && (issue_cnt_q == nbytes_q - 3'd1)) state_d = ST_DONE;
                end else begin
                    if (pend_q && (recv_cnt_q == nbytes_q - 3'd1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_wd    = wd_q;
                state_d = ST_IDLE;
                if (!memop_is_store(op_q)) begin
                    o_wreg  = 1'b1;
                    o_wdata = DATA_W'(ext_wdata);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are held at zero for as long as reset is asserted.
        if (!rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_a     = '0;
            mem_dout  = 8'h00;
            stall_req = 1'b0;
            o_wd      = 5'd0;
            o_wreg    = 1'b0;
            o_wdata   = '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'd0;
            addr_q      <= '0;
            store_q     <= '0;
            wd_q        <= 5'd0;
            nbytes_q    <= 3'd0;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            pend_q      <= 1'b0;
            lanes_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && (state_d == ST_ACCESS)) begin
                op_q        <= ex_memop;
                addr_q      <= ex_mem_addr;
                store_q     <= ex_store_data;
                wd_q        <= ex_wd;
                nbytes_q    <= memop_nbytes(ex_memop);
                issue_cnt_q <= 3'd0;
                recv_cnt_q  <= 3'd0;
                pend_q      <= 1'b0;
                lanes_q     <= 32'd0;
            end else if (state_q == ST_ACCESS) begin
                if (grant_c) issue_cnt_q <= issue_cnt_q + 3'd1;
                // Read data follows its grant by one cycle and arrives in issue order.
                pend_q <= grant_c && !memop_is_store(op_q);
                if (pend_q) begin
                    lanes_q[{recv_cnt_q[1:0], 3'b000} +: 8] <= mem_din;
                    recv_cnt_q <= recv_cnt_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected byte transactions and write-backs are queued by stimulus.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_memop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        stall_req;
    logic [4:0]  o_wd;
    logic        o_wreg;
    logic [31:0] o_wdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_wd         (ex_wd),
        .ex_wreg       (ex_wreg),
        .ex_wdata      (ex_wdata),
        .ex_memop      (ex_memop),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .mem_req       (mem_req),
        .mem_gnt       (mem_gnt),
        .mem_we        (mem_we),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign      (misalign),
`endif
        .stall_req     (stall_req),
        .o_wd          (o_wd),
        .o_wreg        (o_wreg),
        .o_wdata       (o_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [7:0]  d;
    } mem_exp_t;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] data;
    } wb_exp_t;

    mem_exp_t memq[$];
    wb_exp_t  wbq[$];
    int total = 0;
    int bad   = 0;

    logic [7:0] mem_model [0:1023];
    logic       rd_hit = 1'b0;
    logic [9:0] rd_addr = 10'd0;

    // Byte memory responder: read data is valid exactly one cycle after its grant.
    always @(posedge clk) begin
        rd_hit  <= rst && mem_req && mem_gnt && !mem_we;
        rd_addr <= mem_a[9:0];
    end
    assign mem_din = rd_hit ? mem_model[rd_addr] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [7:0] d);
        mem_exp_t e;
        e.a = a; e.we = we; e.d = d;
        memq.push_back(e);
    endtask

    task automatic push_wb(input logic [4:0] wd, input logic [31:0] data);
        wb_exp_t e;
        e.wd = wd; e.data = data;
        wbq.push_back(e);
    endtask

    // Monitor: any requested byte must match the queue head; grants retire it; write-backs pop wbq.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_req) begin
                if (memq.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    check("mem_a", mem_a, memq[0].a);
                    check("mem_we", 32'(mem_we), 32'(memq[0].we));
                    if (memq[0].we) check("mem_dout", 32'(mem_dout), 32'(memq[0].d));
                    if (mem_gnt) void'(memq.pop_front());
                end
            end
            if (o_wreg) begin
                if (wbq.size() == 0) begin
                    check("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    wb_exp_t w;
                    w = wbq.pop_front();
                    check("o_wd", 32'(o_wd), 32'(w.wd));
                    check("o_wdata", o_wdata, w.data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_memop      = MEMOP_NONE;
        ex_wd         = 5'd0;
        ex_wreg       = 1'b0;
        ex_wdata      = 32'd0;
        ex_mem_addr   = 32'd0;
        ex_store_data = 32'd0;
    endtask

    // Presents one op until its DONE cycle; gnt is low only in cycle gap_cyc (cycle 0 = op appears).
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input int gap_cyc, input int exp_stall);
        int  cyc;
        int  nstall;
        bit  done;
        logic is_ld;
        is_ld         = !memop_is_store(op);
        ex_memop      = op;
        ex_mem_addr   = addr;
        ex_store_data = sdata;
        ex_wd         = wd;
        ex_wreg       = is_ld;
        ex_wdata      = 32'hDEAD_BEEF;
        cyc = 0; nstall = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            mem_gnt = (cyc == gap_cyc) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (cyc == 0) check("op_wreg_blocked", 32'(o_wreg), 32'd0);
            if (stall_req) begin
                nstall++;
            end else begin
                done = 1'b1;
                check("done_wreg", 32'(o_wreg), 32'(is_ld));
                check("done_wd", 32'(o_wd), 32'(wd));
                if (!is_ld) check("store_wdata", o_wdata, 32'd0);
            end
            next_cycle();
            cyc++;
        end
        if (!done) check("op_timeout", 32'd0, 32'd1);
        check("stall_cycles", 32'(nstall), 32'(exp_stall));
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
        mem_model[10'h100] = 8'h78; mem_model[10'h101] = 8'h56;
        mem_model[10'h102] = 8'h34; mem_model[10'h103] = 8'h12;
        mem_model[10'h104] = 8'hAA; mem_model[10'h105] = 8'hBB;
        mem_model[10'h201] = 8'h80;
        mem_model[10'h202] = 8'hF0; mem_model[10'h203] = 8'h8F;

        rst = 1'b0;
        mem_gnt = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_wreg", 32'(o_wreg), 32'd0);
        next_cycle();
        rst = 1'b1;

        // ALU passthrough, same cycle, no traffic
        ex_memop = MEMOP_NONE; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h0000_1234;
        mem_gnt = 1'b1;
        push_wb(5'd5, 32'h0000_1234);
        @(negedge clk);
        check("pass_wd", 32'(o_wd), 32'd5);
        check("pass_wreg", 32'(o_wreg), 32'd1);
        check("pass_wdata", o_wdata, 32'h0000_1234);
        check("pass_stall", 32'(stall_req), 32'd0);
        check("pass_req", 32'(mem_req), 32'd0);
        next_cycle();
        // unknown op code behaves as NONE
        ex_memop = 4'd12; ex_wd = 5'd6; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_0001;
        push_wb(5'd6, 32'hCAFE_0001);
        @(negedge clk);
        check("unk_stall", 32'(stall_req), 32'd0);
        next_cycle();
        idle_inputs();

        // LW 0x100, continuous grant
        for (int i = 0; i < 4; i++) push_mem(32'h100 + 32'(i), 1'b0, 8'h00);
        push_wb(5'd7, 32'h1234_5678);
        run_op(MEMOP_LW, 32'h100, 32'h0, 5'd7, -1, 6);

        push_mem(32'h201, 1'b0, 8'h00);
        push_wb(5'd8, 32'hFFFF_FF80);
        run_op(MEMOP_LB, 32'h201, 32'h0, 5'd8, -1, 3);

        push_mem(32'h201, 1'b0, 8'h00);
        push_wb(5'd9, 32'h0000_0080);
        run_op(MEMOP_LBU, 32'h201, 32'h0, 5'd9, -1, 3);

        push_mem(32'h202, 1'b0, 8'h00); push_mem(32'h203, 1'b0, 8'h00);
        push_wb(5'd10, 32'hFFFF_8FF0);
        run_op(MEMOP_LH, 32'h202, 32'h0, 5'd10, -1, 4);

        push_mem(32'h202, 1'b0, 8'h00); push_mem(32'h203, 1'b0, 8'h00);
        push_wb(5'd11, 32'h0000_8FF0);
        run_op(MEMOP_LHU, 32'h202, 32'h0, 5'd11, -1, 4);

        push_mem(32'h3FC, 1'b1, 8'h44); push_mem(32'h3FD, 1'b1, 8'h33);
        push_mem(32'h3FE, 1'b1, 8'h22); push_mem(32'h3FF, 1'b1, 8'h11);
        run_op(MEMOP_SW, 32'h3FC, 32'h1122_3344, 5'd12, -1, 5);

`ifndef MEM_ALIGN_CHECK_EN
        // SH at odd address with a grant gap in cycle 2
        push_mem(32'h301, 1'b1, 8'hCD); push_mem(32'h302, 1'b1, 8'hAB);
        run_op(MEMOP_SH, 32'h301, 32'h0000_ABCD, 5'd13, 2, 4);

        // misaligned LW proceeds byte-serially
        for (int i = 0; i < 4; i++) push_mem(32'h102 + 32'(i), 1'b0, 8'h00);
        push_wb(5'd14, 32'hBBAA_1234);
        run_op(MEMOP_LW, 32'h102, 32'h0, 5'd14, -1, 6);
`endif

        // reset mid-LW after two grants
        push_mem(32'h100, 1'b0, 8'h00); push_mem(32'h101, 1'b0, 8'h00);
        ex_memop = MEMOP_LW; ex_mem_addr = 32'h100; ex_wd = 5'd15; ex_wreg = 1'b1;
        mem_gnt = 1'b1;
        @(negedge clk);
        check("rlw_stall0", 32'(stall_req), 32'd1);
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rlw_rst_req", 32'(mem_req), 32'd0);
        check("rlw_rst_stall", 32'(stall_req), 32'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rlw_req", 32'(mem_req), 32'd0);
        check("rlw_stall", 32'(stall_req), 32'd0);
        check("rlw_we", 32'(mem_we), 32'd0);
        check("rlw_a", mem_a, 32'd0);
        check("rlw_dout", 32'(mem_dout), 32'd0);
        check("rlw_wd", 32'(o_wd), 32'd0);
        check("rlw_wreg", 32'(o_wreg), 32'd0);
        check("rlw_wdata", o_wdata, 32'd0);
        check("rlw_grants_used", 32'(memq.size()), 32'd0);
        next_cycle();

        for (int i = 0; i < 4; i++) push_mem(32'h100 + 32'(i), 1'b0, 8'h00);
        push_wb(5'd16, 32'h1234_5678);
        run_op(MEMOP_LW, 32'h100, 32'h0, 5'd16, -1, 6);

`ifdef MEM_ALIGN_CHECK_EN
        ex_memop = MEMOP_LW; ex_mem_addr = 32'h102; ex_wd = 5'd17; ex_wreg = 1'b1;
        @(negedge clk);
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_stall", 32'(stall_req), 32'd0);
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_wreg", 32'(o_wreg), 32'd0);
        next_cycle();
        ex_memop = MEMOP_SH; ex_mem_addr = 32'h301; ex_store_data = 32'h0000_ABCD;
        ex_wreg = 1'b0;
        @(negedge clk);
        check("mis_sh_pulse", 32'(misalign), 32'd1);
        check("mis_sh_req", 32'(mem_req), 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("mis_clear", 32'(misalign), 32'd0);
        next_cycle();
`endif

        next_cycle();
        check("memq_empty", 32'(memq.size()), 32'd0);
        check("wbq_empty", 32'(wbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage RISC-V pipeline.
- Sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Executes LB/LH/LW/LBU/LHU/SB/SH/SW as a sequence of byte transactions on a byte-wide memory-controller port.
- Stalls the pipeline while an access is in flight; passes non-memory results through unchanged.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-low
- ex_wd  in  5  destination register from EX/MEM
- ex_wreg  in  1  write-enable from EX/MEM
- ex_wdata  in  32  ALU result from EX/MEM
- ex_memop  in  4  memory op code (package encoding; MEMOP_NONE = 0)
- ex_mem_addr  in  32  effective address
- ex_store_data  in  32  store data (rs2)
- mem_req  out  1  byte-transaction request to the memory controller
- mem_gnt  in  1  controller accepts the byte at mem_a this cycle
- mem_we  out  1  1 = write byte, 0 = read byte
- mem_a  out  32  byte address
- mem_dout  out  8  write byte
- mem_din  in  8  read byte; valid exactly one cycle after its grant
- stall_req  out  1  to the stall controller; freezes EX/MEM and earlier stages
- o_wd  out  5  to MEM/WB
- o_wreg  out  1  to MEM/WB
- o_wdata  out  32  to MEM/WB

Behaviour:
- Reset (rst == 0 at a clk edge):
  - State goes to IDLE; counters and assembly buffer clear.
  - mem_req = 0, mem_we = 0, mem_a = 0, mem_dout = 0, stall_req = 0, o_wd = 0, o_wreg = 0, o_wdata = 0.
  - Reset mid-access abandons the access; no further grants are consumed.
- States:
  - IDLE:
    - ex_memop == NONE: outputs combinationally equal ex_wd/ex_wreg/ex_wdata; stall_req = 0.
    - Memory op: stall_req = 1 combinationally, o_wreg = 0; latch op, address and store data; nbytes = 1/2/4 by width; go to ACCESS.
  - ACCESS:
    - mem_req = 1; mem_a = base + issue_cnt; mem_we = 1 for stores.
    - mem_dout = store_data byte[issue_cnt], little-endian.
    - Each cycle with mem_gnt = 1, issue_cnt increments. mem_req drops once issue_cnt == nbytes.
    - Loads: the byte arriving the cycle after grant k is written into buffer lane k; recv_cnt increments.
    - Stores: go to DONE on the edge where the last byte is granted.
    - Loads: go to DONE on the edge where the last byte is received.
    - stall_req = 1 throughout; o_wreg = 0.
  - DONE (exactly 1 cycle):
    - stall_req = 0; o_wd = latched wd.
    - Loads: o_wreg = 1; o_wdata = assembled value. LB/LH sign-extend; LBU/LHU zero-extend.
    - Stores: o_wreg = 0, o_wdata = 0.
    - Always returns to IDLE.
    - EX/MEM advances on this edge, so the same op is never re-executed.
- Latency with continuous grant:
  - LW: stall_req high 6 cycles; result in cycle 6 after the op first appears.
  - SW: stall_req high 5 cycles.
  - LB: stall_req high 3 cycles.
- Grant gaps: mem_gnt = 0 holds mem_a/mem_dout stable; no timeout.
- mem_gnt while mem_req = 0: ignored.
- Addresses wrap modulo 2^32; misalignment is legal because access is byte-serial.
- Unknown memop codes are treated as NONE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN
- Defined:
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, issues no memory traffic.
  - Adds output misalign (1 bit, reset 0), a single-cycle pulse in that IDLE cycle.
  - In that cycle: stall_req = 0, o_wreg = 0.
- Undefined: no port; misaligned accesses proceed byte-serially.

Decomposition:
- Package mem_pkg:
  - memop encodings (NONE, LB, LH, LW, LBU, LHU, SB, SH, SW)
  - state encoding (IDLE, ACCESS, DONE)
  - function memop_nbytes
  - function memop_is_store
- Sub-module mem_load_ext: combinational; takes 4-byte buffer, width and signedness, outputs the 32-bit write-back value.

Test Plan:
- ADD passthrough: memop = NONE, wd = 5, wreg = 1, wdata = 0x1234 -> same-cycle o_* match, stall_req = 0, mem_req never 1.
- LW at 0x100, memory bytes 0x78,0x56,0x34,0x12, gnt always 1:
  - mem_a = 0x100..0x103 in cycles 1–4;
  - stall_req high cycles 0–5;
  - cycle 6: o_wreg = 1, o_wdata = 0x12345678.
- LB at 0x201 = 0x80 -> o_wdata = 0xFFFFFF80. LBU, same address -> 0x00000080.
- SH data 0xABCD at 0x301 with gnt pattern 1,0,1:
  - writes 0xCD @0x301 and 0xAB @0x302;
  - mem_a held during the gap;
  - DONE with o_wreg = 0.
- Reset asserted mid-LW after 2 grants:
  - next cycle all outputs 0, mem_req = 0, state IDLE;
  - a following LW completes correctly.
- (MEM_ALIGN_CHECK_EN) LW at 0x102 -> misalign pulse for 1 cycle, no mem_req, o_wreg = 0.
